// File: rtl/cv32e40p_instr_obi_responder_if.sv
// Instruction-side OBI bus between a fetch initiator (master) and the responder (slave).
// Signal suffixes are relative to the responder.
interface cv32e40p_instr_obi_responder_if;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o
  );

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o
  );
endinterface

// File: rtl/cv32e40p_instr_obi_responder.sv
// Instruction OBI responder: serves fetches from a word memory, in order, after RESP_LATENCY cycles.
// Grant is combinational; grants stop while the outstanding FIFO is full; responses can be stalled.
module cv32e40p_instr_obi_responder #(
  parameter int ADDR_WIDTH      = 14,
  parameter int RESP_LATENCY    = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cv32e40p_instr_obi_responder_if.slave bus,
  input  logic                  gnt_stall_i,
  input  logic                  rvalid_stall_i,
  input  logic                  load_we_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  logic [31:0]           load_wdata_i,
  output logic [3:0]            outstanding_o,
  output logic                  protocol_err_o
);
  localparam int         MO    = MAX_OUTSTANDING;
  localparam logic [3:0] LAT   = 4'(RESP_LATENCY);
  localparam logic [3:0] DEPTH = 4'(MAX_OUTSTANDING);

  logic [31:0]           r_mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] r_idx [MO];
  logic                  r_err [MO];
  logic                  r_vld [MO];
  logic [3:0]            r_age [MO];
  logic [3:0]            r_cnt;
  logic                  r_pend;
  logic [31:0]           r_pend_addr;
  logic                  r_perr;

  // e_* are the aged entries plus one empty slot past the end, so the shift never indexes out of range
  logic [ADDR_WIDTH-1:0] e_idx [MO+1];
  logic                  e_err [MO+1];
  logic                  e_vld [MO+1];
  logic [3:0]            e_age [MO+1];
  logic [ADDR_WIDTH-1:0] n_idx [MO];
  logic                  n_err [MO];
  logic                  n_vld [MO];
  logic [3:0]            n_age [MO];

  logic                  w_full;
  logic                  w_gnt;
  logic                  w_pop;
  logic                  w_viol;
  logic [ADDR_WIDTH-1:0] w_new_idx;
  logic                  w_new_err;
  logic [3:0]            w_push_slot;

  assign w_full      = (r_cnt == DEPTH);
  assign w_gnt       = rst_n & bus.instr_req_i & ~gnt_stall_i & ~w_full;
  assign w_new_idx   = bus.instr_addr_i[ADDR_WIDTH+1:2];
  assign w_new_err   = |bus.instr_addr_i[31:ADDR_WIDTH+2];
  assign w_pop       = rst_n & r_vld[0] & (r_age[0] == LAT) & ~rvalid_stall_i;
  assign w_push_slot = r_cnt - 4'(w_pop);
  assign w_viol      = rst_n & r_pend & (~bus.instr_req_i | (bus.instr_addr_i != r_pend_addr));

  assign bus.instr_gnt_o    = w_gnt;
  assign bus.instr_rvalid_o = w_pop;
  assign bus.instr_err_o    = r_err[0] & w_pop;
  assign bus.instr_rdata_o  = (r_vld[0] && !r_err[0]) ? r_mem[r_idx[0]] : 32'h0;
  assign outstanding_o      = r_cnt;
  assign protocol_err_o     = r_perr | w_viol;

  always_comb begin
    for (int i = 0; i <= MO; i++) begin
      e_idx[i] = '0;
      e_err[i] = 1'b0;
      e_vld[i] = 1'b0;
      e_age[i] = '0;
    end
    for (int i = 0; i < MO; i++) begin
      e_idx[i] = r_idx[i];
      e_err[i] = r_err[i];
      e_vld[i] = r_vld[i];
      e_age[i] = (r_age[i] < LAT) ? r_age[i] + 4'd1 : r_age[i];
    end
    for (int i = 0; i < MO; i++) begin
      if (w_gnt && (4'(i) == w_push_slot)) begin
        n_idx[i] = w_new_idx;
        n_err[i] = w_new_err;
        n_vld[i] = 1'b1;
        n_age[i] = 4'd1;
      end else if (w_pop) begin
        n_idx[i] = e_idx[i+1];
        n_err[i] = e_err[i+1];
        n_vld[i] = e_vld[i+1];
        n_age[i] = e_age[i+1];
      end else begin
        n_idx[i] = e_idx[i];
        n_err[i] = e_err[i];
        n_vld[i] = e_vld[i];
        n_age[i] = e_age[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MO; i++) begin
        r_idx[i] <= '0;
        r_err[i] <= 1'b0;
        r_vld[i] <= 1'b0;
        r_age[i] <= '0;
      end
      r_cnt       <= '0;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_perr      <= 1'b0;
    end else begin
      for (int i = 0; i < MO; i++) begin
        r_idx[i] <= n_idx[i];
        r_err[i] <= n_err[i];
        r_vld[i] <= n_vld[i];
        r_age[i] <= n_age[i];
      end
      r_cnt       <= r_cnt + 4'(w_gnt) - 4'(w_pop);
      r_pend      <= bus.instr_req_i & ~w_gnt;
      r_pend_addr <= bus.instr_addr_i;
      if (w_viol) r_perr <= 1'b1;
    end
  end

  // Preload port; contents survive reset
  always_ff @(posedge clk) begin
    if (load_we_i) r_mem[load_addr_i] <= load_wdata_i;
  end
endmodule

// File: tb/tb_cv32e40p_instr_obi_responder.sv
// Directed bench: instance a (latency 1, depth 2) and instance b (latency 2, depth 3).
module tb_cv32e40p_instr_obi_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        gnt_stall, rv_stall, load_we;
  logic [13:0] load_addr;
  logic [31:0] load_wdata;
  logic [3:0]  outst_a, outst_b;
  logic        perr_a, perr_b;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  cv32e40p_instr_obi_responder_if ifa ();
  cv32e40p_instr_obi_responder_if ifb ();

  cv32e40p_instr_obi_responder #(.ADDR_WIDTH(14), .RESP_LATENCY(1), .MAX_OUTSTANDING(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .gnt_stall_i(gnt_stall), .rvalid_stall_i(rv_stall),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata),
    .outstanding_o(outst_a), .protocol_err_o(perr_a)
  );

  cv32e40p_instr_obi_responder #(.ADDR_WIDTH(14), .RESP_LATENCY(2), .MAX_OUTSTANDING(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .gnt_stall_i(gnt_stall), .rvalid_stall_i(rv_stall),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata),
    .outstanding_o(outst_b), .protocol_err_o(perr_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  function automatic logic [31:0] memval(input int i);
    return 32'hA000_0000 | 32'(i);
  endfunction

  bit bp_gnt [11] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0};
  bit bp_rv  [11] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
  int bp_cnt [11] = '{0, 1, 2, 2, 2, 2, 2, 1, 1, 1, 0};

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nidx, rvidx, peak, exp_cnt;
    rst_n = 1'b0; gnt_stall = 1'b0; rv_stall = 1'b0;
    load_we = 1'b0; load_addr = '0; load_wdata = '0;
    ifa.instr_req_i = 1'b1; ifa.instr_addr_i = 32'h40;
    ifb.instr_req_i = 1'b0; ifb.instr_addr_i = 32'h0;

    // reset state, with a request held during reset
    step(); mid();
    check("rst_gnt", 32'(ifa.instr_gnt_o), 0);
    check("rst_rvalid", 32'(ifa.instr_rvalid_o), 0);
    check("rst_err", 32'(ifa.instr_err_o), 0);
    check("rst_rdata", ifa.instr_rdata_o, 0);
    check("rst_outst", 32'(outst_a), 0);
    check("rst_perr", 32'(perr_a), 0);
    step();
    ifa.instr_req_i = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      load_we = 1'b1; load_addr = 14'(i); load_wdata = memval(i);
      step();
    end
    load_addr = 14'h10; load_wdata = 32'hDEAD_BEEF;
    step();
    load_we = 1'b0;
    step();

    // basic fetch
    ifa.instr_req_i = 1'b1; ifa.instr_addr_i = 32'h40;
    mid();
    check("basic_gnt", 32'(ifa.instr_gnt_o), 1);
    check("basic_rv0", 32'(ifa.instr_rvalid_o), 0);
    step();
    ifa.instr_req_i = 1'b0;
    mid();
    check("basic_rvalid", 32'(ifa.instr_rvalid_o), 1);
    check("basic_rdata", ifa.instr_rdata_o, 32'hDEAD_BEEF);
    check("basic_err", 32'(ifa.instr_err_o), 0);
    check("basic_outst", 32'(outst_a), 1);
    step(); mid();
    check("basic_idle_rv", 32'(ifa.instr_rvalid_o), 0);
    check("basic_idle_outst", 32'(outst_a), 0);
    step();

    // streaming on instance b
    peak = 0;
    for (int c = 0; c < 12; c++) begin
      ifb.instr_req_i = (c < 8);
      ifb.instr_addr_i = 32'(c * 4);
      mid();
      check($sformatf("strm_gnt%0d", c), 32'(ifb.instr_gnt_o), (c < 8) ? 1 : 0);
      check($sformatf("strm_rv%0d", c), 32'(ifb.instr_rvalid_o), (c >= 2 && c <= 9) ? 1 : 0);
      if (c >= 2 && c <= 9) check($sformatf("strm_dat%0d", c), ifb.instr_rdata_o, memval(c - 2));
      exp_cnt = ((c < 8) ? c : 8) - ((c < 2) ? 0 : ((c - 2 > 8) ? 8 : c - 2));
      check($sformatf("strm_cnt%0d", c), 32'(outst_b), 32'(exp_cnt));
      if (int'(outst_b) > peak) peak = int'(outst_b);
      step();
    end
    check("strm_peak", 32'(peak), 2);
    check("strm_perr", 32'(perr_b), 0);

    // backpressure on instance a
    nidx = 0; rvidx = 0;
    for (int c = 0; c < 11; c++) begin
      rv_stall = (c < 6);
      ifa.instr_req_i = (c < 9);
      ifa.instr_addr_i = 32'(nidx * 4);
      mid();
      check($sformatf("bp_gnt%0d", c), 32'(ifa.instr_gnt_o), 32'(bp_gnt[c]));
      check($sformatf("bp_rv%0d", c), 32'(ifa.instr_rvalid_o), 32'(bp_rv[c]));
      check($sformatf("bp_cnt%0d", c), 32'(outst_a), 32'(bp_cnt[c]));
      if (bp_rv[c]) begin
        check($sformatf("bp_dat%0d", c), ifa.instr_rdata_o, memval(rvidx));
        rvidx++;
      end
      if (bp_gnt[c]) nidx++;
      step();
    end
    rv_stall = 1'b0;
    check("bp_perr", 32'(perr_a), 0);

    // error response then in-range request
    ifa.instr_req_i = 1'b1; ifa.instr_addr_i = 32'h0001_0000;
    mid();
    check("err_gnt", 32'(ifa.instr_gnt_o), 1);
    step();
    ifa.instr_addr_i = 32'h8;
    mid();
    check("err_rvalid", 32'(ifa.instr_rvalid_o), 1);
    check("err_err", 32'(ifa.instr_err_o), 1);
    check("err_rdata", ifa.instr_rdata_o, 0);
    check("err_gnt2", 32'(ifa.instr_gnt_o), 1);
    step();
    ifa.instr_req_i = 1'b0;
    mid();
    check("ok_rvalid", 32'(ifa.instr_rvalid_o), 1);
    check("ok_err", 32'(ifa.instr_err_o), 0);
    check("ok_rdata", ifa.instr_rdata_o, memval(2));
    step();

    // reset with two transactions outstanding
    rv_stall = 1'b1;
    ifa.instr_req_i = 1'b1; ifa.instr_addr_i = 32'h0;
    step();
    ifa.instr_addr_i = 32'h4;
    step();
    ifa.instr_req_i = 1'b0; rv_stall = 1'b0; rst_n = 1'b0;
    mid();
    check("mrst_cnt_before", 32'(outst_a), 2);
    check("mrst_rv_in_rst", 32'(ifa.instr_rvalid_o), 0);
    step();
    rst_n = 1'b1;
    mid();
    check("mrst_outst", 32'(outst_a), 0);
    check("mrst_rv0", 32'(ifa.instr_rvalid_o), 0);
    step(); mid();
    check("mrst_rv1", 32'(ifa.instr_rvalid_o), 0);
    step();
    ifa.instr_req_i = 1'b1; ifa.instr_addr_i = 32'h40;
    mid();
    check("mrst_gnt", 32'(ifa.instr_gnt_o), 1);
    step();
    ifa.instr_req_i = 1'b0;
    mid();
    check("mrst_rvalid", 32'(ifa.instr_rvalid_o), 1);
    check("mrst_rdata", ifa.instr_rdata_o, 32'hDEAD_BEEF);
    step();

    // protocol violation: address changes while the request is not granted
    gnt_stall = 1'b1;
    ifa.instr_req_i = 1'b1; ifa.instr_addr_i = 32'h100;
    mid();
    check("prot_gnt", 32'(ifa.instr_gnt_o), 0);
    check("prot_perr0", 32'(perr_a), 0);
    step();
    ifa.instr_addr_i = 32'h104;
    mid();
    check("prot_perr1", 32'(perr_a), 1);
    step();
    ifa.instr_req_i = 1'b0; gnt_stall = 1'b0;
    mid();
    check("prot_perr2", 32'(perr_a), 1);
    step(); mid();
    check("prot_perr3", 32'(perr_a), 1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    mid();
    check("prot_perr_clr", 32'(perr_a), 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
